// File: rtl/pwm_breath_sequencer.sv
// Single-channel LED PWM with a built-in duty sequencer (OFF, ON, breathing).
// Commands are buffered in a one-deep pending slot and applied only on period boundaries.
module pwm_breath_sequencer #(
    parameter int unsigned PERIOD = 12000,
    parameter int unsigned DW     = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [1:0]    cmd_mode,
    input  logic [DW-1:0] cmd_step,
    input  logic [7:0]    cmd_hold,
    output logic          led,
    output logic          out_tick,
    output logic [DW-1:0] duty,
    output logic [2:0]    state
);

    localparam logic [DW-1:0] PeriodVal = DW'(PERIOD);
    localparam logic [DW-1:0] LastCnt   = DW'(PERIOD - 1);

    typedef enum logic [2:0] {
        StOff    = 3'd0,
        StOn     = 3'd1,
        StUp     = 3'd2,
        StHoldHi = 3'd3,
        StDown   = 3'd4,
        StHoldLo = 3'd5
    } state_e;

    logic [DW-1:0] pwm_cnt_q;
    logic          tick;

    logic          pend_valid_q;
    logic [1:0]    pend_mode_q;
    logic [DW-1:0] pend_step_q;
    logic [7:0]    pend_hold_q;

    state_e        state_q, state_d;
    logic [DW-1:0] duty_q, duty_d;
    logic [DW-1:0] step_q, step_d;
    logic [7:0]    hold_q, hold_d;
    logic [7:0]    hold_cnt_q, hold_cnt_d;
    logic [DW:0]   sum;

    assign tick      = (pwm_cnt_q == LastCnt);
    assign out_tick  = tick;
    assign led       = (pwm_cnt_q < duty_q);
    assign duty      = duty_q;
    assign state     = state_q;
    assign cmd_ready = ~pend_valid_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt_q <= '0;
        end else if (tick) begin
            pwm_cnt_q <= '0;
        end else begin
            pwm_cnt_q <= pwm_cnt_q + 1'b1;
        end
    end

    // Ready is the inverse of the pending flag, so accept and apply never coincide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_valid_q <= 1'b0;
            pend_mode_q  <= '0;
            pend_step_q  <= '0;
            pend_hold_q  <= '0;
        end else if (tick && pend_valid_q) begin
            pend_valid_q <= 1'b0;
        end else if (cmd_valid && cmd_ready) begin
            pend_valid_q <= 1'b1;
            pend_mode_q  <= cmd_mode;
            pend_step_q  <= cmd_step;
            pend_hold_q  <= cmd_hold;
        end
    end

    always_comb begin
        state_d    = state_q;
        duty_d     = duty_q;
        step_d     = step_q;
        hold_d     = hold_q;
        hold_cnt_d = hold_cnt_q;
        sum        = {1'b0, duty_q} + {1'b0, step_q};
        if (tick && pend_valid_q) begin
            unique case (pend_mode_q)
                2'd1: begin
                    duty_d  = PeriodVal;
                    state_d = StOn;
                end
                2'd2: begin
                    step_d     = (pend_step_q == '0) ? DW'(1) : pend_step_q;
                    hold_d     = pend_hold_q;
                    hold_cnt_d = '0;
                    state_d    = (duty_q == PeriodVal) ? StDown : StUp;
                end
                default: begin
                    duty_d  = '0;
                    state_d = StOff;
                end
            endcase
        end else if (tick) begin
            unique case (state_q)
                StOff, StOn: ;
                StUp: begin
                    if (sum >= {1'b0, PeriodVal}) begin
                        duty_d  = PeriodVal;
                        state_d = (hold_q == '0) ? StDown : StHoldHi;
                    end else begin
                        duty_d = sum[DW-1:0];
                    end
                end
                StDown: begin
                    if (duty_q <= step_q) begin
                        duty_d  = '0;
                        state_d = (hold_q == '0) ? StUp : StHoldLo;
                    end else begin
                        duty_d = duty_q - step_q;
                    end
                end
                StHoldHi, StHoldLo: begin
                    if (hold_cnt_q + 8'd1 == hold_q) begin
                        hold_cnt_d = '0;
                        state_d    = (state_q == StHoldHi) ? StDown : StUp;
                    end else begin
                        hold_cnt_d = hold_cnt_q + 8'd1;
                    end
                end
                default: state_d = StOff;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StOff;
            duty_q     <= '0;
            step_q     <= DW'(1);
            hold_q     <= '0;
            hold_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            duty_q     <= duty_d;
            step_q     <= step_d;
            hold_q     <= hold_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

endmodule

// File: tb/tb_pwm_breath_sequencer.sv
// Directed bench for pwm_breath_sequencer with PERIOD=10; inputs change and outputs
// are sampled on the falling clock edge.
module tb_pwm_breath_sequencer;

    localparam int unsigned PERIOD = 10;
    localparam int unsigned DW     = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_mode;
    logic [DW-1:0] cmd_step;
    logic [7:0]    cmd_hold;
    logic          led;
    logic          out_tick;
    logic [DW-1:0] duty;
    logic [2:0]    state;

    int total = 0;
    int bad   = 0;

    pwm_breath_sequencer #(
        .PERIOD (PERIOD),
        .DW     (DW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_mode  (cmd_mode),
        .cmd_step  (cmd_step),
        .cmd_hold  (cmd_hold),
        .led       (led),
        .out_tick  (out_tick),
        .duty      (duty),
        .state     (state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance to the next tick cycle, then one cycle past it (pwm_cnt=0).
    task automatic wait_tick();
        for (int n = 0; n < 3 * PERIOD && out_tick !== 1'b1; n++) @(negedge clk);
        if (out_tick !== 1'b1) chk("tick_timeout", {31'd0, out_tick}, 32'd1);
        @(negedge clk);
    endtask

    initial begin : stim
        int exp_duty [14];
        int exp_state[14];
        exp_duty  = '{0, 3, 6, 9, 10, 10, 10, 7, 4, 1, 0, 0, 0, 3};
        exp_state = '{2, 2, 2, 2, 3, 3, 4, 4, 4, 4, 5, 5, 2, 2};

        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_mode  = 2'd0;
        cmd_step  = '0;
        cmd_hold  = '0;
        repeat (5) @(negedge clk);
        chk("rst_led", {31'd0, led}, 32'd0);
        chk("rst_duty", {16'd0, duty}, 32'd0);
        chk("rst_state", {29'd0, state}, 32'd0);
        chk("rst_ready", {31'd0, cmd_ready}, 32'd1);
        chk("rst_tick", {31'd0, out_tick}, 32'd0);
        rst_n = 1'b1;

        // Idle: tick on cycles 9 and 19 only.
        for (int k = 0; k < 20; k++) begin
            chk("idle_tick", {31'd0, out_tick}, (k % 10 == 9) ? 32'd1 : 32'd0);
            if (k == 5) chk("idle_led", {31'd0, led}, 32'd0);
            @(negedge clk);
        end

        // ON command presented at pwm_cnt=3.
        repeat (3) @(negedge clk);
        cmd_valid = 1'b1;
        cmd_mode  = 2'd1;
        @(negedge clk);
        cmd_valid = 1'b0;
        for (int k = 4; k < 10; k++) begin
            chk("on_ready_low", {31'd0, cmd_ready}, 32'd0);
            chk("on_duty_old", {16'd0, duty}, 32'd0);
            @(negedge clk);
        end
        chk("on_duty", {16'd0, duty}, 32'd10);
        chk("on_state", {29'd0, state}, 32'd1);
        chk("on_ready_back", {31'd0, cmd_ready}, 32'd1);
        begin
            int lows = 0;
            for (int k = 0; k < 20; k++) begin
                if (led !== 1'b1) lows++;
                @(negedge clk);
            end
            chk("on_led_lows", lows, 0);
        end

        // Back to OFF, then BREATHE step 3 hold 2.
        cmd_valid = 1'b1;
        cmd_mode  = 2'd0;
        @(negedge clk);
        cmd_valid = 1'b0;
        wait_tick();
        chk("off_duty", {16'd0, duty}, 32'd0);
        chk("off_state", {29'd0, state}, 32'd0);
        cmd_valid = 1'b1;
        cmd_mode  = 2'd2;
        cmd_step  = 16'd3;
        cmd_hold  = 8'd2;
        @(negedge clk);
        cmd_valid = 1'b0;
        wait_tick();
        for (int i = 0; i < 14; i++) begin
            chk("br_duty", {16'd0, duty}, exp_duty[i]);
            chk("br_state", {29'd0, state}, exp_state[i]);
            if (i < 13) wait_tick();
        end

        // Continue to 6, 9, 10, 10, 10(DOWN), 7(DOWN).
        repeat (6) wait_tick();
        chk("pre_rst_duty", {16'd0, duty}, 32'd7);
        chk("pre_rst_state", {29'd0, state}, 32'd4);
        chk("pre_rst_led", {31'd0, led}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_duty", {16'd0, duty}, 32'd0);
        chk("mid_rst_state", {29'd0, state}, 32'd0);
        chk("mid_rst_led", {31'd0, led}, 32'd0);
        chk("mid_rst_ready", {31'd0, cmd_ready}, 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // PWM shape at duty 4: BREATHE step 4 hold 1 from OFF.
        cmd_valid = 1'b1;
        cmd_mode  = 2'd2;
        cmd_step  = 16'd4;
        cmd_hold  = 8'd1;
        @(negedge clk);
        cmd_valid = 1'b0;
        wait_tick();
        chk("shape_apply_state", {29'd0, state}, 32'd2);
        wait_tick();
        chk("shape_duty", {16'd0, duty}, 32'd4);
        for (int k = 0; k < 10; k++) begin
            chk("shape_led", {31'd0, led}, (k < 4) ? 32'd1 : 32'd0);
            @(negedge clk);
        end

        // Back-to-back: ON then OFF with cmd_valid held.
        cmd_valid = 1'b1;
        cmd_mode  = 2'd1;
        @(negedge clk);
        chk("b2b_ready_low", {31'd0, cmd_ready}, 32'd0);
        cmd_mode = 2'd0;
        wait_tick();
        chk("b2b_on_duty", {16'd0, duty}, 32'd10);
        chk("b2b_on_state", {29'd0, state}, 32'd1);
        chk("b2b_ready_hi", {31'd0, cmd_ready}, 32'd1);
        chk("b2b_led0", {31'd0, led}, 32'd1);
        @(negedge clk);
        chk("b2b_off_accepted", {31'd0, cmd_ready}, 32'd0);
        cmd_valid = 1'b0;
        for (int k = 1; k < 10; k++) begin
            chk("b2b_on_period", {31'd0, led}, 32'd1);
            @(negedge clk);
        end
        chk("b2b_off_duty", {16'd0, duty}, 32'd0);
        chk("b2b_off_state", {29'd0, state}, 32'd0);
        chk("b2b_off_led", {31'd0, led}, 32'd0);
        chk("b2b_ready_end", {31'd0, cmd_ready}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
